tt_sweep_capture7: RTL and testbench
====================================

Name: tt_sweep_capture7

Overview:
- Sequential truth-table extractor placed directly upstream/downstream of a 7-input combinational classification function (majority-gate network under test).
- Drives all 128 input vectors onto the function's x0..x6 inputs, samples its single output, and assembles a 128-bit truth table plus a ones-count.
- Compares the table against a supplied expected table and presents the result over a valid/ready handshake, for classification regression and on-chip self-check.

Parameters:
- SETTLE, 1, clock cycles each input vector is held before the function output is sampled (legal range 1..15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a sweep; accepted only in IDLE
- busy  out  1  high while a sweep is in progress (RUN state)
- x  out  7  vector to function under test; x[0] drives x0 ... x[6] drives x6
- f_in  in  1  output of function under test (combinational from x)
- expected_tt  in  128  reference table; sampled at start acceptance
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_tt  out  128  captured table; bit i = f_in when x == i
- res_ones  out  8  number of 1 bits in res_tt (0..128)
- res_match  out  1  res_tt == captured expected_tt

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, x=0, busy=0, res_valid=0, res_tt=0, res_ones=0, res_match=0, internal index/settle counters=0, expected register=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge -> RUN; x<=0; settle counter<=0; res_tt<=0; res_ones<=0; expected register<=expected_tt. Sampling of expected_tt happens only here.
- RUN: busy=1. Settle counter counts 0..SETTLE-1.
- At the edge where the counter equals SETTLE-1: res_tt[x]<=f_in; res_ones increments if f_in=1; counter<=0; x<=x+1.
- Each vector is therefore held exactly SETTLE cycles. f_in is sampled on the last edge of that window.
- At the sampling edge for x==127: capture bit 127 and go to DONE. x wraps to 0 (7-bit natural wrap). res_valid<=1. res_match<=(final table == expected register), computed including bit 127 in that same edge.
- res_valid rises exactly 128*SETTLE edges after the start acceptance edge.
- res_ones width: 8 bits. Value 128 must be representable; no saturation needed.
- DONE: res_valid=1. res_tt, res_ones and res_match are held stable until the handshake completes.
- res_ready=1 in DONE -> IDLE at that edge; res_valid<=0. Outputs keep their values until the next start acceptance.
- start is ignored in RUN and DONE; it is not queued.
- start and res_ready both high in DONE: only the handshake completes. The new start needs IDLE, so earliest acceptance is the following edge.
- res_ready outside DONE has no effect.
- rst asserted mid-sweep or in DONE: immediate return to reset values; the partial table is discarded.
- f_in is not registered internally beyond the capture. The function under test must settle within SETTLE cycles of x changing.

Decomposition:
- Shared package tt_pkg:
  - typedef tt_state_t {IDLE, RUN, DONE}
  - localparam N_IN=7, TT_BITS=128, ONES_W=8
  - typedef tt_vec_t (logic [TT_BITS-1:0])
- One natural sub-module, tt_settle_ctr: settle counter with a sample-strobe output; counter width derived from SETTLE.
- Table shift/write, popcount increment and compare stay in the top.

Test Plan:
- f_in tied to x[0], SETTLE=1, expected_tt=128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA -> res_valid 128 cycles after start; res_tt=that value; res_ones=64; res_match=1.
- f_in = AND of all x bits, expected_tt=0 -> res_tt=128'h8000_0000_0000_0000_0000_0000_0000_0000; res_ones=1; res_match=0.
- f_in constant 1, SETTLE=3 -> res_valid exactly 384 cycles after start; res_ones=128 (8'h80); res_tt all ones.
- Backpressure: hold res_ready=0 for 20 cycles after res_valid, pulse start meanwhile -> outputs stable, no new sweep. Then res_ready=1 for 1 cycle -> IDLE next edge, res_valid=0.
- rst asserted at sweep cycle 50 -> x=0, busy=0, res_valid=0 immediately (asynchronously). A subsequent start produces a correct full table.
- f_in = 7-input majority (popcount(x)>=4) -> res_ones=64; bit 7=0, bit 15=1, bit 127=1.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and sizes for the 7-input truth-table sweep/capture block.
package tt_pkg;

  localparam int unsigned N_IN    = 7;
  localparam int unsigned TT_BITS = 128;
  localparam int unsigned ONES_W  = 8;

  typedef logic [TT_BITS-1:0] tt_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tt_state_t;

  // Counter width able to hold 0..settle-1 (at least one bit).
  function automatic int unsigned ctr_width(input int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/tt_settle_ctr.sv
// Per-vector settle counter; strobes on the last cycle of each SETTLE-cycle window.
module tt_settle_ctr
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic strobe_c
);

  localparam int unsigned    CW   = ctr_width(SETTLE);
  localparam logic [CW-1:0]  LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign strobe_c = enable && (cnt == LAST);

endmodule

// File: rtl/tt_sweep_capture7.sv
// Sweeps all 128 vectors through a 7-input function, captures its truth table,
// ones-count and match against a reference, and hands the result off via valid/ready.
module tt_sweep_capture7
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic [N_IN-1:0]      x,
  input  logic                 f_in,
  input  logic [TT_BITS-1:0]   expected_tt,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [TT_BITS-1:0]   res_tt,
  output logic [ONES_W-1:0]    res_ones,
  output logic                 res_match
);

  localparam logic [N_IN-1:0] X_LAST = N_IN'(TT_BITS - 1);

  tt_state_t state, next_state;
  tt_vec_t   exp_q;
  tt_vec_t   tt_wr;
  logic      accept_c;
  logic      run_c;
  logic      sample_c;
  logic      last_c;

  tt_settle_ctr #(.SETTLE(SETTLE)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept_c),
    .enable   (run_c),
    .strobe_c (sample_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state plus the table image including the bit being sampled this cycle.
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    run_c      = (state == RUN);
    tt_wr      = res_tt;
    tt_wr[x]   = f_in;
    last_c     = sample_c && (x == X_LAST);
    case (state)
      IDLE: if (start) begin
        next_state = RUN;
        accept_c   = 1'b1;
      end
      RUN:  if (last_c)    next_state = DONE;
      DONE: if (res_ready) next_state = IDLE;
      default:             next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_tt    <= '0;
      res_ones  <= '0;
      res_match <= 1'b0;
      exp_q     <= '0;
    end else begin
      if (accept_c) begin
        x        <= '0;
        busy     <= 1'b1;
        res_tt   <= '0;
        res_ones <= '0;
        exp_q    <= expected_tt;
      end
      if (sample_c) begin
        res_tt   <= tt_wr;
        res_ones <= res_ones + ONES_W'(f_in);
        x        <= x + N_IN'(1);
      end
      // Final vector: the compare must see bit 127 captured on this same edge.
      if (last_c) begin
        busy      <= 1'b0;
        res_valid <= 1'b1;
        res_match <= (tt_wr == exp_q);
      end
      if ((state == DONE) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tt_sweep_capture7.sv
// Directed + randomized bench for tt_sweep_capture7 with SETTLE=1 and SETTLE=3 instances.
module tb_tt_sweep_capture7;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         start1, ready1, f1, busy1, valid1, match1;
  logic [6:0]   x1;
  logic [127:0] exp1, tt1;
  logic [7:0]   ones1;

  logic         start3, ready3, f3, busy3, valid3, match3;
  logic [6:0]   x3;
  logic [127:0] exp3, tt3;
  logic [7:0]   ones3;

  int           mode;
  logic [127:0] rnd_tbl;
  int           n_pass  = 0;
  int           n_total = 0;

  tt_sweep_capture7 #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .x(x1), .f_in(f1),
    .expected_tt(exp1), .res_valid(valid1), .res_ready(ready1),
    .res_tt(tt1), .res_ones(ones1), .res_match(match1)
  );

  tt_sweep_capture7 #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .x(x3), .f_in(f3),
    .expected_tt(exp3), .res_valid(valid3), .res_ready(ready3),
    .res_tt(tt3), .res_ones(ones3), .res_match(match3)
  );

  // Function under test, selected by mode: 0 x0, 1 AND7, 2 const 1, 3 majority, 4 random table.
  function automatic logic fn_of(input int m, input logic [127:0] tbl, input int unsigned i);
    int bits;
    bits = 0;
    for (int k = 0; k < 7; k++) bits += int'((i >> k) & 1);
    case (m)
      0:       return (i % 2) == 1;
      1:       return i == 127;
      2:       return 1'b1;
      3:       return bits >= 4;
      4:       return tbl[i[6:0]];
      default: return 1'b0;
    endcase
  endfunction

  always_comb f1 = fn_of(mode, rnd_tbl, {25'd0, x1});
  always_comb f3 = fn_of(mode, rnd_tbl, {25'd0, x3});

  function automatic logic [127:0] model_tt(input int m, input logic [127:0] tbl);
    logic [127:0] t;
    for (int i = 0; i < 128; i++) t[i] = fn_of(m, tbl, i);
    return t;
  endfunction

  function automatic int popcnt(input logic [127:0] t);
    int c;
    c = 0;
    for (int i = 0; i < 128; i++) if (t[i]) c++;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic read_out(input int which, output logic v, output logic b,
                          output logic [127:0] t, output logic [7:0] o,
                          output logic m, output logic [6:0] xo);
    if (which == 1) begin v = valid1; b = busy1; t = tt1; o = ones1; m = match1; xo = x1; end
    else            begin v = valid3; b = busy3; t = tt3; o = ones3; m = match3; xo = x3; end
  endtask

  task automatic set_in(input int which, input logic s, input logic r, input logic [127:0] e);
    if (which == 1) begin start1 = s; ready1 = r; exp1 = e; end
    else            begin start3 = s; ready3 = r; exp3 = e; end
  endtask

  task automatic sweep(input int which, input int m, input logic [127:0] expt, input string tag);
    logic [127:0] want, t;
    logic [7:0]   o;
    logic [6:0]   xo;
    logic         v, b, mt;
    int           cyc;
    mode = m;
    want = model_tt(m, rnd_tbl);
    @(negedge clk);
    set_in(which, 1'b1, 1'b0, expt);
    @(negedge clk);
    set_in(which, 1'b0, 1'b0, ~expt);
    read_out(which, v, b, t, o, mt, xo);
    chk({tag, "_busy"}, 128'(b), 128'(1'b1));
    cyc = 0;
    while (!v && cyc < 128 * which + 20) begin
      @(negedge clk);
      cyc++;
      read_out(which, v, b, t, o, mt, xo);
    end
    chk({tag, "_latency"}, 128'(cyc), 128'(128 * which));
    chk({tag, "_tt"},      t,         want);
    chk({tag, "_ones"},    128'(o),   128'(popcnt(want)));
    chk({tag, "_match"},   128'(mt),  128'(want == expt));
    chk({tag, "_x_wrap"},  128'(xo),  128'(0));
    chk({tag, "_idle"},    128'(b),   128'(1'b0));
  endtask

  task automatic handshake(input int which, input string tag);
    logic [127:0] t;
    logic [7:0]   o;
    logic [6:0]   xo;
    logic         v, b, mt;
    @(negedge clk);
    set_in(which, 1'b0, 1'b1, '0);
    @(negedge clk);
    set_in(which, 1'b0, 1'b0, '0);
    read_out(which, v, b, t, o, mt, xo);
    chk({tag, "_hs_valid"}, 128'(v), 128'(1'b0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] t, want, e;
    logic [7:0]   o;
    logic [6:0]   xo;
    logic         v, b, mt;
    int           w;

    rst = 1'b1; mode = 0; rnd_tbl = '0;
    start1 = 0; ready1 = 0; exp1 = '0;
    start3 = 0; ready3 = 0; exp3 = '0;
    #12;
    read_out(1, v, b, t, o, mt, xo);
    chk("rst_valid", 128'(v), 128'(0));
    chk("rst_busy",  128'(b), 128'(0));
    chk("rst_x",     128'(xo), 128'(0));
    chk("rst_tt",    t, 128'(0));
    chk("rst_ones",  128'(o), 128'(0));
    chk("rst_match", 128'(mt), 128'(0));
    chk("rst_valid3", 128'(valid3), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    sweep(1, 0, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, "x0");
    chk("x0_tt_const", tt1, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    chk("x0_ones_const", 128'(ones1), 128'(64));
    handshake(1, "x0");

    sweep(1, 1, '0, "and7");
    chk("and7_tt_const", tt1, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    chk("and7_match_const", 128'(match1), 128'(0));
    handshake(1, "and7");

    sweep(3, 2, '1, "const1");
    chk("const1_ones_const", 128'(ones3), 128'(8'h80));
    // Backpressure: result must hold and start pulses must be ignored.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      set_in(3, (k % 3) == 0, 1'b0, '0);
    end
    @(negedge clk);
    set_in(3, 1'b0, 1'b0, '0);
    chk("bp_valid", 128'(valid3), 128'(1));
    chk("bp_busy",  128'(busy3),  128'(0));
    chk("bp_tt",    tt3,          '1);
    chk("bp_ones",  128'(ones3),  128'(128));
    // start together with ready: only the handshake completes.
    set_in(3, 1'b1, 1'b1, '0);
    @(negedge clk);
    set_in(3, 1'b0, 1'b0, '0);
    chk("sr_valid", 128'(valid3), 128'(0));
    chk("sr_busy",  128'(busy3),  128'(0));
    @(negedge clk);
    chk("sr_busy2", 128'(busy3),  128'(0));
    chk("sr_hold_tt", tt3, '1);

    want = model_tt(3, rnd_tbl);
    sweep(1, 3, want, "maj");
    chk("maj_ones_const", 128'(ones1), 128'(64));
    chk("maj_bit7",   128'(tt1[7]),   128'(0));
    chk("maj_bit15",  128'(tt1[15]),  128'(1));
    chk("maj_bit127", 128'(tt1[127]), 128'(1));
    handshake(1, "maj");

    // Asynchronous reset in the middle of a sweep.
    mode = 0;
    @(negedge clk);
    set_in(1, 1'b1, 1'b0, '0);
    @(negedge clk);
    set_in(1, 1'b0, 1'b0, '0);
    repeat (49) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_x",     128'(x1),     128'(0));
    chk("arst_busy",  128'(busy1),  128'(0));
    chk("arst_valid", 128'(valid1), 128'(0));
    chk("arst_tt",    tt1,          128'(0));
    @(negedge clk);
    rst = 1'b0;
    sweep(1, 0, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, "post_rst");
    handshake(1, "post_rst");

    for (int r = 0; r < 4; r++) begin
      rnd_tbl = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) e = rnd_tbl;
      else e = rnd_tbl ^ (128'(1) << $urandom_range(0, 127));
      w = ((r % 2) == 1) ? 3 : 1;
      sweep(w, 4, e, $sformatf("rnd%0d", r));
      handshake(w, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
